// File: rtl/dilithium_pkg.sv
// Shared Dilithium control definitions: mode/security-level encodings, error
// codes, sequencer states and the command legality check.
package dilithium_pkg;

    localparam logic [1:0] MODE_KEYGEN = 2'd0;
    localparam logic [1:0] MODE_VERIFY = 2'd1;
    localparam logic [1:0] MODE_SIGN   = 2'd2;

    localparam logic [2:0] SEC_LVL_2 = 3'd2;
    localparam logic [2:0] SEC_LVL_3 = 3'd3;
    localparam logic [2:0] SEC_LVL_5 = 3'd5;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_ILLEGAL = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_ABORTED = 2'd3
    } err_code_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_ABORT = 3'd3,
        ST_DONE  = 3'd4
    } op_state_t;

    function automatic logic sec_lvl_legal(input logic [2:0] sec_lvl);
        return sec_lvl inside {SEC_LVL_2, SEC_LVL_3, SEC_LVL_5};
    endfunction

    function automatic logic cmd_legal(input logic [1:0] mode, input logic [2:0] sec_lvl);
        return (mode inside {MODE_KEYGEN, MODE_VERIFY, MODE_SIGN}) && sec_lvl_legal(sec_lvl);
    endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Counts consecutive enabled cycles without a clear; trips on the LIMIT-th one.
module stall_watchdog #(
    parameter int unsigned LIMIT = 65536
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic trip
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        count <= '0;
        else if (clear) count <= '0;
        else if (en)    count <= count + W'(1);
    end

    // A clear in the same cycle means progress was made, so never trip then.
    assign trip = en && !clear && (count == W'(LIMIT - 1));

endmodule

// File: rtl/op_sequencer.sv
// Operation controller: accepts and validates a command, pulses start, watches
// the output stream for the LAST beat and reports status, cycle count and aborts.
module op_sequencer
    import dilithium_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [2:0]       cmd_sec_lvl,
    input  logic             abort,
    output logic             start,
    output logic [1:0]       mode,
    output logic [2:0]       sec_lvl,
    output logic             core_clear,
    input  logic             out_valid,
    input  logic             out_ready,
    input  logic             out_last,
    output logic             busy,
    output logic             op_done,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] cycle_count
);
    op_state_t state, state_nxt;
    err_code_t err_q, err_nxt;

    logic accept, legal, beat, last_beat, trip;

    assign accept    = cmd_valid && (state == ST_IDLE);
    assign legal     = cmd_legal(cmd_mode, cmd_sec_lvl);
    assign beat      = out_valid && out_ready;
    assign last_beat = beat && out_last;

    stall_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
        .clk   (clk),
        .rst   (rst),
        .clear ((state == ST_START) || ((state == ST_RUN) && beat)),
        .en    (state == ST_RUN),
        .trip  (trip)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            err_q <= ERR_OK;
        end else begin
            state <= state_nxt;
            err_q <= err_nxt;
        end
    end

    // Completion beats abort, abort beats the watchdog.
    always_comb begin
        state_nxt = state;
        err_nxt   = err_q;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = legal ? ST_START : ST_DONE;
                    err_nxt   = legal ? ERR_OK : ERR_ILLEGAL;
                end
            end
            ST_START: state_nxt = ST_RUN;
            ST_RUN: begin
                if (last_beat) begin
                    state_nxt = ST_DONE;
                end else if (abort) begin
                    state_nxt = ST_ABORT;
                    err_nxt   = ERR_ABORTED;
                end else if (trip) begin
                    state_nxt = ST_ABORT;
                    err_nxt   = ERR_TIMEOUT;
                end
            end
            ST_ABORT: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode        <= '0;
            sec_lvl     <= '0;
            cycle_count <= '0;
        end else if (accept) begin
            mode        <= cmd_mode;
            sec_lvl     <= cmd_sec_lvl;
            cycle_count <= '0;
        end else if (((state == ST_START) || (state == ST_RUN)) && (cycle_count != '1)) begin
            cycle_count <= cycle_count + CNT_W'(1);
        end
    end

    assign cmd_ready  = (state == ST_IDLE);
    assign start      = (state == ST_START);
    assign core_clear = (state == ST_ABORT);
    assign op_done    = (state == ST_DONE);
    assign busy       = (state == ST_START) || (state == ST_RUN) || (state == ST_ABORT);
    assign err_code   = err_q;

endmodule

// File: doc/op_sequencer.md
# op_sequencer

Top-level operation controller for the Dilithium core and its output stream adapter. Accepts one command (mode, security level) per operation over a valid/ready handshake and validates it. Issues the single-cycle start to core and adapter, then watches the AXI-Stream output until the LAST beat is taken. Reports completion, error code and cycle count, and aborts on software request or output stall via a watchdog.

## Interface
- TIMEOUT_CYCLES, default 65536: stall limit in cycles without an output beat during RUN.
- CNT_W, default 32: width of cycle_count.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_mode  in  2  0 keygen, 1 verify, 2 sign, 3 illegal.
- cmd_sec_lvl  in  3  legal values 2, 3, 5.
- abort  in  1  software abort request, level-sampled.
- start  out  1  one-cycle pulse to core and stream adapter.
- mode  out  2  registered mode, held from accept until next accept.
- sec_lvl  out  3  registered security level, held the same way.
- core_clear  out  1  one-cycle pulse in ABORT, ORed into core/adapter reset.
- out_valid, out_ready, out_last  in  1 each  taps of the adapter's external stream.
- busy  out  1  high in START, RUN, ABORT.
- op_done  out  1  one-cycle pulse in DONE.
- err_code  out  2  0 ok, 1 illegal cmd, 2 timeout, 3 aborted; held until next accept.
- cycle_count  out  CNT_W  cycles from start pulse through the last-beat cycle, saturating.

## Operation
- States: IDLE, START, RUN, ABORT, DONE.
- IDLE -> START: on cmd_valid && cmd_ready with a legal command.
  - Latches mode and sec_lvl; clears err_code and cycle_count.
- IDLE -> DONE: on acceptance of an illegal command (mode 3 or sec_lvl not in {2,3,5}).
  - Sets err_code=1; no start, no core_clear.
  - mode/sec_lvl are still latched for debug.
- START -> RUN: unconditional; start=1 for exactly this cycle.
- RUN -> DONE: on beat = out_valid && out_ready && out_last.
- RUN -> ABORT, abort=1: err_code=3.
- RUN -> ABORT, watchdog reaches TIMEOUT_CYCLES: err_code=2.
- ABORT -> DONE: unconditional; core_clear=1 for this cycle.
- DONE -> IDLE: unconditional.
- Watchdog:
  - Clears in START and on any out_valid && out_ready in RUN.
  - Otherwise increments in RUN.
  - Trip when count == TIMEOUT_CYCLES-1 and no beat this cycle.
- cycle_count:
  - Counts from the START cycle (value 1 in START) through the last-beat cycle inclusive.
  - Saturates at all-ones; frozen outside START/RUN.
- abort in IDLE or DONE is ignored. abort in START is deferred: RUN is entered first, and abort is honored there if still high.

## Timing
- Reset values:
  - state IDLE; cmd_ready=1.
  - start, core_clear, busy, op_done all 0.
  - mode=0, sec_lvl=0, err_code=0, cycle_count=0.
- All outputs are registered state decodes or registers; no combinational path from cmd_* or out_* to any output except cmd_ready (pure state decode).
- Accept at edge N -> start high in cycle N+1 -> RUN from N+2.
- Last beat at edge M -> op_done high in cycle M+1 -> cmd_ready high in M+2.
- Minimum command-to-command spacing is 4 cycles for a 1-word verify output accepted immediately.
- Simultaneous events:
  - Last beat and abort in the same RUN cycle: completion wins, err_code=0.
  - Last beat and watchdog trip cannot coincide (a beat clears the watchdog).
- Reset mid-operation returns to IDLE immediately with no pulse on any output; the core is reset by the same rst.
- cmd_valid while not in IDLE is ignored; the command is not consumed.

## Structure
- Shared package dilithium_pkg holds:
  - mode encodings (MODE_KEYGEN=0, MODE_VERIFY=1, MODE_SIGN=2);
  - legal sec_lvl constants;
  - err_code enum;
  - op_state_t enum.
- Legality check is a package function, reused by the adapter's size decode.
- One sub-module: stall_watchdog (clear, en, limit parameter, trip output).
- cycle_count stays inline.

## Test plan
- Keygen, sec_lvl 2, sink always ready, 480 words with LAST on word 480:
  - start exactly one cycle after accept; op_done one cycle after the LAST beat;
  - err_code=0; cycle_count = 1 + RUN cycles, exactly.
- cmd_mode=3, sec_lvl=2 → no start, op_done one cycle after accept, err_code=1, cmd_ready back 2 cycles after accept. Repeat with cmd_mode=0, sec_lvl=4: same response.
- Verify, sec_lvl 5, TIMEOUT_CYCLES=16, out_ready held 0:
  - ABORT on the 16th stalled RUN cycle;
  - core_clear one cycle, then op_done with err_code=2.
- Sign, sec_lvl 3, abort pulsed after 100 beats → core_clear, then op_done with err_code=3. Then abort in the same cycle as the LAST beat → err_code=0.
- Async rst asserted mid-RUN → all outputs at reset values immediately. After release a new keygen command completes normally.
- CNT_W=4 with a run longer than 15 cycles → cycle_count saturates at 15. cmd_valid held high while busy → exactly one accept per operation.
